// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the single-bus datapath control unit:
// sequencer states, opcode map and instruction-register field positions.
package cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_T0,
        ST_T1,
        ST_T1W,
        ST_T2,
        ST_T3,
        ST_T4,
        ST_T5,
        ST_T6,
        ST_RETIRE,
        ST_HALTED,
        ST_ILLEGAL
    } state_e;

    localparam logic [4:0] OP_ALU_FIRST = 5'h03;
    localparam logic [4:0] OP_ALU_LAST  = 5'h0D;
    localparam logic [4:0] OP_MUL       = 5'h0E;
    localparam logic [4:0] OP_DIV       = 5'h0F;
    localparam logic [4:0] OP_HALT      = 5'h1F;

    localparam int IR_OPC_LSB = 27;
    localparam int IR_RA_LSB  = 23;
    localparam int IR_RB_LSB  = 19;
    localparam int IR_RC_LSB  = 15;

    function automatic logic is_alu(input logic [4:0] op);
        return (op >= OP_ALU_FIRST) && (op <= OP_ALU_LAST);
    endfunction

    function automatic logic is_muldiv(input logic [4:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/reg_select_decoder.sv
// Turns a 4-bit register index plus enable into a one-hot select vector.
// Indices at or beyond NREGS produce an all-zero vector.
module reg_select_decoder #(
    parameter int NREGS = 16
) (
    input  logic [3:0]       idx,
    input  logic             en,
    output logic [NREGS-1:0] onehot
);

    always_comb begin
        onehot = '0;
        for (int i = 0; i < NREGS; i++) begin
            onehot[i] = en && (32'(idx) == i);
        end
    end

endmodule

// File: rtl/alu_sequencer.sv
// Hardwired fetch/execute sequencer for three-register ALU, MUL and DIV instructions.
// Strobes are Moore outputs decoded from the state register and the IR contents.
module alu_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int NREGS = 16,
    parameter int CNT_W = 16
) (
    input  logic             Clock,
    input  logic             Reset_n,
    input  logic             Run,
    input  logic             Mem_ready,
    input  logic [31:0]      IR_data,
    output logic             PCout,
    output logic             Zlowout,
    output logic             ZHighout,
    output logic             MDRout,
    output logic             MARin,
    output logic             PCin,
    output logic             MDRin,
    output logic             IRin,
    output logic             Yin,
    output logic             Zin,
    output logic             LOin,
    output logic             HIin,
    output logic             IncPC,
    output logic             Read,
    output logic [NREGS-1:0] Reg_in,
    output logic [NREGS-1:0] Reg_out,
    output logic [4:0]       operation,
    output logic             Busy,
    output logic             Illegal,
    output logic [CNT_W-1:0] Instr_count
);

    state_e           state_q, state_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [4:0] opc;
    logic [3:0] ra, rb, rc;
    logic       op_alu, op_md, regs_ok;
    logic       unused_ir;

    assign opc       = IR_data[IR_OPC_LSB +: 5];
    assign ra        = IR_data[IR_RA_LSB +: 4];
    assign rb        = IR_data[IR_RB_LSB +: 4];
    assign rc        = IR_data[IR_RC_LSB +: 4];
    assign unused_ir = ^IR_data[IR_RC_LSB-1:0];

    assign op_alu  = is_alu(opc);
    assign op_md   = is_muldiv(opc);
    assign regs_ok = (32'(ra) < NREGS) && (32'(rb) < NREGS) && (32'(rc) < NREGS);

    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        count_d   = count_q;
        case (state_q)
            ST_IDLE:    if (Run) state_d = ST_T0;
            ST_T0:      state_d = ST_T1;
            // Wait cycles live in T1W so PCin is only ever a single-cycle pulse.
            ST_T1,
            ST_T1W:     state_d = Mem_ready ? ST_T2 : ST_T1W;
            ST_T2:      state_d = ST_T3;
            ST_T3: begin
                if (opc == OP_HALT) begin
                    state_d = ST_HALTED;
                end else if ((op_alu || op_md) && regs_ok) begin
                    state_d = ST_T4;
                end else begin
                    state_d   = ST_ILLEGAL;
                    illegal_d = 1'b1;
                end
            end
            ST_T4:      state_d = ST_T5;
            ST_T5:      state_d = op_md ? ST_T6 : ST_RETIRE;
            ST_T6:      state_d = ST_RETIRE;
            ST_RETIRE: begin
                count_d = count_q + CNT_W'(1);
                state_d = Run ? ST_T0 : ST_IDLE;
            end
            ST_HALTED:  state_d = ST_HALTED;
            ST_ILLEGAL: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= ST_IDLE;
            illegal_q <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            count_q   <= count_d;
        end
    end

    always_comb begin
        PCout     = 1'b0;
        Zlowout   = 1'b0;
        ZHighout  = 1'b0;
        MDRout    = 1'b0;
        MARin     = 1'b0;
        PCin      = 1'b0;
        MDRin     = 1'b0;
        IRin      = 1'b0;
        Yin       = 1'b0;
        Zin       = 1'b0;
        LOin      = 1'b0;
        HIin      = 1'b0;
        IncPC     = 1'b0;
        Read      = 1'b0;
        operation = 5'd0;
        case (state_q)
            ST_T0: begin
                PCout = 1'b1;
                MARin = 1'b1;
                IncPC = 1'b1;
                Zin   = 1'b1;
            end
            ST_T1, ST_T1W: begin
                Zlowout = 1'b1;
                PCin    = (state_q == ST_T1);
                Read    = 1'b1;
                MDRin   = 1'b1;
            end
            ST_T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            ST_T3:  Yin = 1'b1;
            ST_T4: begin
                Zin       = 1'b1;
                operation = opc;
            end
            ST_T5: begin
                Zlowout = 1'b1;
                LOin    = op_md;
            end
            ST_T6: begin
                ZHighout = 1'b1;
                HIin     = 1'b1;
            end
            default: ;
        endcase
    end

    reg_select_decoder #(.NREGS(NREGS)) u_reg_in_dec (
        .idx    (ra),
        .en     ((state_q == ST_T5) && op_alu),
        .onehot (Reg_in)
    );

    reg_select_decoder #(.NREGS(NREGS)) u_reg_out_dec (
        .idx    ((state_q == ST_T3) ? rb : rc),
        .en     ((state_q == ST_T3) || (state_q == ST_T4)),
        .onehot (Reg_out)
    );

    assign Busy        = (state_q != ST_IDLE) && (state_q != ST_HALTED);
    assign Illegal     = illegal_q;
    assign Instr_count = count_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: stimulus queues the expected per-cycle
// output pattern of each instruction, a monitor compares every busy cycle.
module tb_alu_sequencer;

    localparam int NR = 12;
    localparam int CW = 4;

    localparam logic [13:0] M_PCOUT  = 14'h2000;
    localparam logic [13:0] M_ZLOW   = 14'h1000;
    localparam logic [13:0] M_ZHIGH  = 14'h0800;
    localparam logic [13:0] M_MDROUT = 14'h0400;
    localparam logic [13:0] M_MARIN  = 14'h0200;
    localparam logic [13:0] M_PCIN   = 14'h0100;
    localparam logic [13:0] M_MDRIN  = 14'h0080;
    localparam logic [13:0] M_IRIN   = 14'h0040;
    localparam logic [13:0] M_YIN    = 14'h0020;
    localparam logic [13:0] M_ZIN    = 14'h0010;
    localparam logic [13:0] M_LOIN   = 14'h0008;
    localparam logic [13:0] M_HIIN   = 14'h0004;
    localparam logic [13:0] M_INCPC  = 14'h0002;
    localparam logic [13:0] M_READ   = 14'h0001;

    typedef struct packed {
        logic [13:0]   st;
        logic [NR-1:0] rin;
        logic [NR-1:0] rout;
        logic [4:0]    op;
        logic          ill;
        logic [CW-1:0] cnt;
    } rec_t;

    logic          Clock, Reset_n, Run, Mem_ready;
    logic [31:0]   IR_data;
    logic          PCout, Zlowout, ZHighout, MDRout, MARin, PCin, MDRin, IRin;
    logic          Yin, Zin, LOin, HIin, IncPC, Read, Busy, Illegal;
    logic [NR-1:0] Reg_in, Reg_out;
    logic [4:0]    operation;
    logic [CW-1:0] Instr_count;

    alu_sequencer #(.NREGS(NR), .CNT_W(CW)) dut (
        .Clock(Clock), .Reset_n(Reset_n), .Run(Run), .Mem_ready(Mem_ready),
        .IR_data(IR_data), .PCout(PCout), .Zlowout(Zlowout), .ZHighout(ZHighout),
        .MDRout(MDRout), .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin),
        .Yin(Yin), .Zin(Zin), .LOin(LOin), .HIin(HIin), .IncPC(IncPC), .Read(Read),
        .Reg_in(Reg_in), .Reg_out(Reg_out), .operation(operation), .Busy(Busy),
        .Illegal(Illegal), .Instr_count(Instr_count)
    );

    int            checks = 0;
    int            failures = 0;
    int            busy_cycles = 0;
    int            seq_idx = 0;
    int            wait_cfg = 0;
    int            rd_cnt = 0;
    rec_t          exp_q[$];
    logic [CW-1:0] exp_cnt = '0;
    logic          exp_ill = 1'b0;

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    function automatic rec_t snap();
        rec_t r;
        r.st   = {PCout, Zlowout, ZHighout, MDRout, MARin, PCin, MDRin, IRin,
                  Yin, Zin, LOin, HIin, IncPC, Read};
        r.rin  = Reg_in;
        r.rout = Reg_out;
        r.op   = operation;
        r.ill  = Illegal;
        r.cnt  = Instr_count;
        return r;
    endfunction

    function automatic logic [NR-1:0] oh(input logic [3:0] i);
        logic [NR-1:0] v;
        v = '0;
        for (int k = 0; k < NR; k++) if (int'(i) == k) v[k] = 1'b1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push(input logic [13:0] st, input logic [NR-1:0] rin,
                        input logic [NR-1:0] rout, input logic [4:0] op);
        rec_t r;
        r.st = st; r.rin = rin; r.rout = rout; r.op = op;
        r.ill = exp_ill; r.cnt = exp_cnt;
        exp_q.push_back(r);
    endtask

    // Expected busy-cycle outputs of one instruction, straight from the strobe table.
    task automatic push_instr(input logic [31:0] ir, input int waits);
        logic [4:0] op;
        logic [3:0] ra, rb, rc;
        op = ir[31:27]; ra = ir[26:23]; rb = ir[22:19]; rc = ir[18:15];
        push(M_PCOUT | M_MARIN | M_INCPC | M_ZIN, '0, '0, 5'd0);
        push(M_ZLOW | M_PCIN | M_READ | M_MDRIN, '0, '0, 5'd0);
        for (int w = 0; w < waits; w++) push(M_ZLOW | M_READ | M_MDRIN, '0, '0, 5'd0);
        push(M_MDROUT | M_IRIN, '0, '0, 5'd0);
        push(M_YIN, '0, oh(rb), 5'd0);
        if (op == 5'h1F) return;
        if (op < 5'h03 || op > 5'h0F || int'(ra) >= NR || int'(rb) >= NR || int'(rc) >= NR) begin
            exp_ill = 1'b1;
            push(14'h0, '0, '0, 5'd0);
            return;
        end
        push(M_ZIN, '0, oh(rc), op);
        if (op <= 5'h0D) begin
            push(M_ZLOW, oh(ra), '0, 5'd0);
        end else begin
            push(M_ZLOW | M_LOIN, '0, '0, 5'd0);
            push(M_ZHIGH | M_HIIN, '0, '0, 5'd0);
        end
        push(14'h0, '0, '0, 5'd0);
        exp_cnt = exp_cnt + 1'b1;
    endtask

    // Memory model: holds Mem_ready low for wait_cfg read cycles of each fetch.
    always @(negedge Clock) begin
        if (Read) begin
            Mem_ready = (rd_cnt >= wait_cfg);
            rd_cnt++;
        end else begin
            Mem_ready = 1'b0;
            rd_cnt = 0;
        end
    end

    always @(negedge Clock) begin : monitor
        rec_t e;
        if (Reset_n && Busy) begin
            busy_cycles++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_busy actual=%0h required=idle", snap());
            end else begin
                e = exp_q.pop_front();
                chk($sformatf("seq_%0d", seq_idx), snap(), e);
                seq_idx++;
            end
        end
    end

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        @(negedge Clock); #2;
        while ((exp_q.size() != 0 || Busy) && n < budget) begin
            @(negedge Clock); #2;
            n++;
        end
        checks++;
        if (n >= budget) begin
            failures++;
            $display("FAIL %s_timeout actual=pending%0d required=0", name, exp_q.size());
        end
    endtask

    task automatic run_one(input string name, input logic [31:0] ir, input int waits,
                           input int cycles);
        @(negedge Clock); #2;
        IR_data = ir;
        wait_cfg = waits;
        busy_cycles = 0;
        push_instr(ir, waits);
        Run = 1'b1;
        @(negedge Clock); #2;
        Run = 1'b0;
        wait_idle(name, 40);
        chk({name, "_cycles"}, 64'(busy_cycles), 64'(cycles));
    endtask

    initial begin : watchdog
        #60000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        Reset_n = 1'b0; Run = 1'b0; Mem_ready = 1'b0; IR_data = 32'h0;
        repeat (2) @(negedge Clock);
        #2;
        chk("reset_outputs", 64'(snap()), 64'h0);
        chk("reset_busy", 64'(Busy), 64'h0);
        Reset_n = 1'b1;
        repeat (2) @(negedge Clock);
        chk("idle_busy", 64'(Busy), 64'h0);

        run_one("add", 32'h18918000, 0, 7);
        chk("add_count", 64'(Instr_count), 64'h1);
        run_one("add_wait", 32'h18918000, 3, 10);
        chk("add_wait_count", 64'(Instr_count), 64'h2);
        run_one("mul", 32'h70228000, 0, 8);
        chk("mul_count", 64'(Instr_count), 64'h3);
        run_one("bad_reg", 32'h18E98000, 0, 5);
        chk("bad_reg_illegal", 64'(Illegal), 64'h1);
        chk("bad_reg_count", 64'(Instr_count), 64'h3);
        run_one("bad_opc", 32'hD0918000, 0, 5);
        chk("bad_opc_illegal", 64'(Illegal), 64'h1);
        chk("bad_opc_count", 64'(Instr_count), 64'h3);

        // 13 back-to-back instructions: the count reaches 15, then wraps on the last.
        @(negedge Clock); #2;
        IR_data = 32'h6AAA8000;
        wait_cfg = 0;
        for (int i = 0; i < 13; i++) push_instr(32'h6AAA8000, 0);
        Run = 1'b1;
        repeat (88) @(posedge Clock);
        #2;
        chk("wrap_in_t3", 64'(Yin), 64'h1);
        Run = 1'b0;
        wait_idle("wrap", 40);
        chk("wrap_count", 64'(Instr_count), 64'h0);
        chk("wrap_busy", 64'(Busy), 64'h0);

        @(negedge Clock); #2;
        IR_data = 32'hF8000000;
        push_instr(32'hF8000000, 0);
        Run = 1'b1;
        wait_idle("halt", 40);
        for (int i = 0; i < 20; i++) begin
            @(negedge Clock); #2;
            chk($sformatf("halted_%0d", i), 64'({Busy, snap().st}), 64'h0);
        end
        Reset_n = 1'b0;
        Run = 1'b0;
        #1;
        chk("halt_reset_outputs", 64'(snap()), 64'h0);
        @(negedge Clock); #2;
        Reset_n = 1'b1;
        exp_cnt = '0;
        exp_ill = 1'b0;

        @(negedge Clock); #2;
        IR_data = 32'h18918000;
        push_instr(32'h18918000, 0);
        Run = 1'b1;
        repeat (5) @(posedge Clock);
        #2;
        chk("t4_operation", 64'(operation), 64'h03);
        chk("t4_reg_out", 64'(Reg_out), 64'h008);
        Reset_n = 1'b0;
        Run = 1'b0;
        #1;
        chk("t4_reset_outputs", 64'({Busy, snap()}), 64'h0);
        exp_q.delete();
        exp_cnt = '0;
        @(negedge Clock); #2;
        Reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clock); #2;
            chk($sformatf("post_reset_%0d", i), 64'({Busy, Reg_in, Instr_count}), 64'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
